// File: rtl/bram_arbiter_pkg.sv
// Shared definitions for the two-port BRAM arbiter: FSM encoding and
// datapath geometry.
package bram_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ACCESS  = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_WAIT    = 3'd3,
    ST_ACK     = 3'd4
  } state_t;

  localparam int NUM_PORTS       = 2;
  localparam int ADDR_WORD_SHIFT = 2;
  localparam int DATA_W          = 32;

endpackage

// File: rtl/bram_arbiter_rr_grant2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the
// port that was not granted last.
module bram_arbiter_rr_grant2
  import bram_arbiter_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 last_grant,
  output logic                 grant_valid,
  output logic                 grant_idx
);

  always_comb begin
    grant_valid = |req;
    grant_idx   = 1'b0;
    if (req == 2'b11) begin
      grant_idx = ~last_grant;
    end else if (req[1]) begin
      grant_idx = 1'b1;
    end
  end

endmodule

// File: rtl/bram_arbiter.sv
// Arbitrates two requesters onto one registered-output BRAM port, one
// transaction at a time, with an optional DELAY-cycle wait before ack.
module bram_arbiter
  import bram_arbiter_pkg::*;
#(
  parameter int unsigned DELAY = 0
) (
  input  logic              axis_clk,
  input  logic              axis_rst_n,
  input  logic              m0_req,
  input  logic [3:0]        m0_we,
  input  logic [31:0]       m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic [3:0]        m1_we,
  input  logic [31:0]       m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              bram_en,
  output logic [3:0]        bram_we,
  output logic [31:0]       bram_addr,
  output logic [DATA_W-1:0] bram_di,
  input  logic [DATA_W-1:0] bram_do,
  output logic [2:0]        dbg_state
);

  // Handshake: a requester raises mN_req with stable we/addr/wdata and holds
  // req until mN_ack; everything is latched at grant, so later input changes
  // or an early req drop do not affect the transaction, which always acks.

  localparam logic [7:0] WAIT_LAST = (DELAY == 0) ? 8'd0 : 8'(DELAY - 1);

  state_t            state, state_n;
  logic              grant_q;
  logic              last_grant;
  logic [3:0]        we_q;
  logic [31:0]       addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [7:0]        cnt;
  logic              gnt_valid;
  logic              gnt_idx;

  bram_arbiter_rr_grant2 u_rr (
    .req         ({m1_req, m0_req}),
    .last_grant  (last_grant),
    .grant_valid (gnt_valid),
    .grant_idx   (gnt_idx)
  );

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state      <= ST_IDLE;
      grant_q    <= 1'b0;
      last_grant <= 1'b1;
      we_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      cnt        <= '0;
    end else begin
      state <= state_n;
      case (state)
        ST_IDLE: begin
          if (gnt_valid) begin
            grant_q    <= gnt_idx;
            last_grant <= gnt_idx;
            we_q       <= gnt_idx ? m1_we    : m0_we;
            addr_q     <= gnt_idx ? m1_addr  : m0_addr;
            wdata_q    <= gnt_idx ? m1_wdata : m0_wdata;
          end
        end
        ST_CAPTURE: begin
          // Captured for writes too: gives read-before-write data on ack.
          rdata_q <= bram_do;
          cnt     <= '0;
        end
        ST_WAIT: cnt <= cnt + 8'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:    if (gnt_valid) state_n = ST_ACCESS;
      ST_ACCESS:  state_n = ST_CAPTURE;
      ST_CAPTURE: state_n = (DELAY == 0) ? ST_ACK : ST_WAIT;
      ST_WAIT:    if (cnt == WAIT_LAST) state_n = ST_ACK;
      ST_ACK:     state_n = ST_IDLE;
      default:    state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    bram_en   = 1'b0;
    bram_we   = '0;
    bram_addr = '0;
    bram_di   = '0;
    if (state == ST_ACCESS) begin
      bram_en   = 1'b1;
      bram_we   = we_q;
      bram_addr = addr_q >> ADDR_WORD_SHIFT;
      bram_di   = wdata_q;
    end
  end

  assign m0_ack    = (state == ST_ACK) && !grant_q;
  assign m1_ack    = (state == ST_ACK) &&  grant_q;
  assign m0_rdata  = m0_ack ? rdata_q : '0;
  assign m1_rdata  = m1_ack ? rdata_q : '0;
  assign dbg_state = state;

endmodule
